// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, types and helpers for the byte-enabled dual-port RAM.
//   BYTE_W      - width of one write lane
//   be_width()  - number of byte lanes in a word of the given width
//   be_merge()  - overlays the enabled byte lanes of a new word onto an old word
//   stage_t     - per-cycle response tag carried down the ack pipeline
package ram_pkg;

   localparam int BYTE_W     = 8;
   localparam int MAX_DATA_W = 1024;
   localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

   typedef struct packed {
      logic a_valid;
      logic b_valid;
      logic coll;
   } stage_t;

   function automatic int be_width(input int data_w);
      return data_w / BYTE_W;
   endfunction

   // Words narrower than MAX_DATA_W are passed zero-extended; only the low
   // lanes of the result are meaningful to the caller.
   function automatic logic [MAX_DATA_W-1:0] be_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) begin
            merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_dp_lane.sv
// ram_dp_lane: one 8-bit byte lane of the dual-port RAM, 2**ADDR_W entries.
//   clk              - clock shared by both ports
//   a_en / b_en      - request accepted this cycle (already gated by reset)
//   a_we / b_we      - lane write enable for the port
//   a_addr / b_addr  - word address
//   a_wdata / b_wdata- write byte
//   a_rdata / b_rdata- post-edge contents of the addressed entry, valid the
//                      cycle after the request (write-first, cross-port forwarded)
// When both ports write the same entry in the same cycle, port A's byte wins.
module ram_dp_lane
   import ram_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [BYTE_W-1:0] a_wdata,
   output logic [BYTE_W-1:0] a_rdata,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [BYTE_W-1:0] b_wdata,
   output logic [BYTE_W-1:0] b_rdata
);

   logic [BYTE_W-1:0] mem [0:(2**ADDR_W)-1];

   logic              a_wr, b_wr, same_addr;
   logic [BYTE_W-1:0] a_mem_reg, b_mem_reg;
   logic [BYTE_W-1:0] a_fwd_reg, b_fwd_reg;
   logic              a_sel_reg, b_sel_reg;

   assign same_addr = (a_addr == b_addr);
   assign a_wr      = a_en & a_we;
   // Port B is suppressed on a same-entry write so port A's byte is the one stored.
   assign b_wr      = b_en & b_we & ~(a_wr & same_addr);

   always_ff @(posedge clk) begin
      if (a_wr) begin
         mem[a_addr] <= a_wdata;
      end
      if (b_wr) begin
         mem[b_addr] <= b_wdata;
      end
   end

   // The array read is plain read-first so it maps onto block RAM; any write
   // landing on the same entry this edge is remembered separately and
   // substituted on the output side.
   always_ff @(posedge clk) begin
      a_mem_reg <= mem[a_addr];
      b_mem_reg <= mem[b_addr];
      a_sel_reg <= a_wr | (b_wr & same_addr);
      a_fwd_reg <= a_wr ? a_wdata : b_wdata;
      b_sel_reg <= b_wr | (a_wr & same_addr);
      b_fwd_reg <= (a_wr & same_addr) ? a_wdata : b_wdata;
   end

   assign a_rdata = a_sel_reg ? a_fwd_reg : a_mem_reg;
   assign b_rdata = b_sel_reg ? b_fwd_reg : b_mem_reg;

endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: single-clock true dual-port RAM with per-byte write enables.
//   clk_i, rst_i            - clock and synchronous active-high reset
//   a_stb_i / b_stb_i       - request valid, accepted every cycle (no stall)
//   a_we_i / b_we_i         - byte-lane write enables, all zero = read
//   a_addr_i / b_addr_i     - word address
//   a_data_i / b_data_i     - write data
//   a_data_o / b_data_o     - post-access word, valid with ack, held otherwise
//   a_ack_o / b_ack_o       - one ack per request, 1+OUT_REG cycles later
//   coll_o                  - pulses with the ack of a same-address pair
//                             where at least one port writes
module ram_dp_be
   import ram_pkg::*;
#(
   parameter  int DATA_W  = 32,
   parameter  int ADDR_W  = 14,
   parameter  int OUT_REG = 0,
   localparam int BE_W    = be_width(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              a_stb_i,
   input  logic [BE_W-1:0]   a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic [DATA_W-1:0] a_data_o,
   output logic              a_ack_o,
   input  logic              b_stb_i,
   input  logic [BE_W-1:0]   b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic [DATA_W-1:0] b_data_o,
   output logic              b_ack_o,
   output logic              coll_o
);

   logic              a_req, b_req, coll_now;
   logic [DATA_W-1:0] a_rd, b_rd;
   stage_t            stage1_reg;

   // A request seen together with reset is dropped, write included.
   assign a_req    = a_stb_i & ~rst_i;
   assign b_req    = b_stb_i & ~rst_i;
   assign coll_now = a_req & b_req & (a_addr_i == b_addr_i) & ((|a_we_i) | (|b_we_i));

   genvar gi;
   generate
      for (gi = 0; gi < BE_W; gi++) begin : g_lane
         ram_dp_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk     (clk_i),
            .a_en    (a_req),
            .a_we    (a_we_i[gi]),
            .a_addr  (a_addr_i),
            .a_wdata (a_data_i[gi*BYTE_W +: BYTE_W]),
            .a_rdata (a_rd[gi*BYTE_W +: BYTE_W]),
            .b_en    (b_req),
            .b_we    (b_we_i[gi]),
            .b_addr  (b_addr_i),
            .b_wdata (b_data_i[gi*BYTE_W +: BYTE_W]),
            .b_rdata (b_rd[gi*BYTE_W +: BYTE_W])
         );
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage1_reg <= '0;
      end else begin
         stage1_reg.a_valid <= a_req;
         stage1_reg.b_valid <= b_req;
         stage1_reg.coll    <= coll_now;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         stage_t            stage2_reg;
         logic [DATA_W-1:0] a_out_reg, b_out_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               stage2_reg <= '0;
               a_out_reg  <= '0;
               b_out_reg  <= '0;
            end else begin
               stage2_reg <= stage1_reg;
               if (stage1_reg.a_valid) begin
                  a_out_reg <= a_rd;
               end
               if (stage1_reg.b_valid) begin
                  b_out_reg <= b_rd;
               end
            end
         end

         assign a_data_o = a_out_reg;
         assign b_data_o = b_out_reg;
         assign a_ack_o  = stage2_reg.a_valid;
         assign b_ack_o  = stage2_reg.b_valid;
         assign coll_o   = stage2_reg.coll;
      end else begin : g_no_out_reg
         // Hold registers keep the last response visible while idle.
         logic [DATA_W-1:0] a_hold_reg, b_hold_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               a_hold_reg <= '0;
               b_hold_reg <= '0;
            end else begin
               if (stage1_reg.a_valid) begin
                  a_hold_reg <= a_rd;
               end
               if (stage1_reg.b_valid) begin
                  b_hold_reg <= b_rd;
               end
            end
         end

         assign a_data_o = stage1_reg.a_valid ? a_rd : a_hold_reg;
         assign b_data_o = stage1_reg.b_valid ? b_rd : b_hold_reg;
         assign a_ack_o  = stage1_reg.a_valid;
         assign b_ack_o  = stage1_reg.b_valid;
         assign coll_o   = stage1_reg.coll;
      end
   endgenerate

endmodule
